mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It sits between the datapath's inst/mem interfaces and the memory. It serializes accesses through a small FSM with a request/ready handshake on each side and a cs/ack handshake toward memory. It also produces the stall indications the pipeline controller uses to freeze stages while an access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  main clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  instruction read request (held until if_ready)
- if_addr  in  ADDR_W  instruction address
- if_data  out  DATA_W  instruction read data, valid when if_ready
- if_ready  out  1  one-cycle completion pulse for IF
- d_ren  in  1  data read request (held until d_ready)
- d_wen  in  1  data write request (held until d_ready)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_ready
- d_ready  out  1  one-cycle completion pulse for data port
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  (d_ren | d_wen) & ~d_ready
- ram_cs  out  1  memory access strobe, held until ram_ack
- ram_we  out  1  write qualifier, valid with ram_cs
- ram_addr  out  ADDR_W  memory address, stable while ram_cs
- ram_wdata  out  DATA_W  memory write data, stable while ram_cs
- ram_rdata  in  DATA_W  memory read data, valid with ram_ack
- ram_ack  in  1  one-cycle completion from memory

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE handles arbitration:
  - If no request is pending, stay in IDLE.
  - If a data request (d_ren|d_wen) is pending, go to BUSY_D.
  - Else if if_req, go to BUSY_I.
  - If both are pending, the data port wins (fixed priority; the MEM-stage instruction is older).
- On grant, register into ram_addr/ram_we/ram_wdata:
  - For IF: if_addr, we=0.
  - For data: d_addr, we=d_wen, wdata=d_wdata.
  - ram_cs=1 from the next cycle.
- If d_ren and d_wen are both high, the access is a write.
- BUSY_x: hold ram_cs and the registered address/data until ram_ack. On ack:
  - capture ram_rdata into if_data or d_rdata (writes leave d_rdata unchanged);
  - drop ram_cs;
  - go to DONE.
- DONE:
  - assert exactly the granted port's ready for one cycle;
  - go to IDLE.
- The requester must deassert or change its request in the ready cycle. A request still high in IDLE is treated as new.
- ram_ack in IDLE or DONE is ignored.
- A request dropped while BUSY (pipeline flush) does not abort the access. The access completes and ready still pulses once.
- if_data and d_rdata hold their last captured value until the next capture.

## Timing
- Reset values:
  - state IDLE;
  - ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0;
  - if_data=0, d_rdata=0;
  - if_ready=0, d_ready=0.
- The stall outputs follow their inputs combinationally.
- Latency: request seen in IDLE at cycle N → ram_cs high in N+1. With ack at cycle N+1+W (W≥0 wait cycles), ready is high at N+2+W.
- Minimum latency is 2 cycles. Maximum throughput is one access per 3 cycles.
- Reset asserted mid-access:
  - state returns to IDLE immediately;
  - ram_cs drops asynchronously;
  - no ready pulse is produced.
  - Memory must tolerate the abandoned strobe.
- ready pulses are registered (state-decoded from registered state); no combinational path from ram_ack to ready.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_grant flop (reset to IF) records the last granted port.
  - On simultaneous requests in IDLE, the port not granted last wins.
  - A single request is always granted.
- MEM_ARB_RR_EN undefined: fixed data-over-IF priority, as above. The last_grant flop is absent.

## Structure
- State encodings (IDLE/BUSY_I/BUSY_D/DONE, 2 bits) and grant encodings (GNT_IF/GNT_D) go in the shared define header alongside the other pipeline constants.
- Single flat module. No sub-module; the FSM and capture registers are too small to split.

## Test plan
- Single IF read: if_addr=0x0000_0010, memory acks W=0 with 0x2002_0005 → ram_cs high exactly 1 cycle, if_ready pulses at cycle N+2, if_data=0x2002_0005, stall_if high N..N+1.
- Data write with waits: d_wen=1, d_addr=0x40, d_wdata=0xDEAD_BEEF, ack after W=3 → ram_we=1, address/data stable for 4 cycles, d_ready at N+5, d_rdata unchanged.
- Simultaneous requests: if_req and d_ren in the same cycle → data served first, IF served after its DONE/IDLE. With MEM_ARB_RR_EN and a repeat collision, IF wins the second round.
- Flush mid-access: drop if_req one cycle after grant → access completes, if_ready pulses once, FSM returns to IDLE, no second ram_cs.
- Async reset during BUSY_D with W=5: assert rst mid-wait → ram_cs=0 and all outputs at reset values without a clock edge. After release, a late ram_ack is ignored.
- Spurious ack in IDLE → no ready pulse, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and grant identifiers.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBusyI = 2'd1,
      StBusyD = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

   typedef enum logic {
      GntIf = 1'b0,
      GntD  = 1'b1
   } arb_grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM ports onto one single-ported memory (cs/ack handshake).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_data,
   output logic              if_ready,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack
);

   arb_state_e state_q;
   logic       d_req;
   logic       pick_d;

   assign d_req     = d_ren | d_wen;
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = d_req & ~d_ready;

`ifdef MEM_ARB_RR_EN
   arb_grant_e last_grant_q;

   // On a collision the port that was not served last goes first.
   always_comb pick_d = d_req & (~if_req | (last_grant_q == GntIf));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= GntIf;
      end else if (state_q == StIdle) begin
         if (pick_d) begin
            last_grant_q <= GntD;
         end else if (if_req) begin
            last_grant_q <= GntIf;
         end
      end
   end
`else
   always_comb pick_d = d_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_data   <= '0;
         d_rdata   <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_d) begin
                  state_q   <= StBusyD;
                  ram_cs    <= 1'b1;
                  ram_we    <= d_wen;
                  ram_addr  <= d_addr;
                  ram_wdata <= d_wdata;
               end else if (if_req) begin
                  state_q  <= StBusyI;
                  ram_cs   <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= if_addr;
               end
            end
            StBusyI: begin
               if (ram_ack) begin
                  if_data  <= ram_rdata;
                  ram_cs   <= 1'b0;
                  if_ready <= 1'b1;
                  state_q  <= StDone;
               end
            end
            StBusyD: begin
               if (ram_ack) begin
                  // Write acks carry no data; keep the last read value visible.
                  if (!ram_we) begin
                     d_rdata <= ram_rdata;
                  end
                  ram_cs  <= 1'b0;
                  d_ready <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timing cases, then randomized traffic
// against a behavioural memory and a per-port scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_ready;
   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        ram_cs;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_data   (if_data),
      .if_ready  (if_ready),
      .d_ren     (d_ren),
      .d_wen     (d_wen),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ack   (ram_ack)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Scoreboard queues and reference model state.
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] last_d = 32'h0;

   // Behavioural memory state.
   logic [31:0] tb_mem[logic [31:0]];
   int          mem_wait_cfg = 0;
   bit          mem_auto = 1'b1;
   logic        manual_ack = 1'b0;
   int          wait_left = -1;
   logic [31:0] cs_addr;
   logic [31:0] cs_wdata;
   logic        cs_we;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_cs"}, ram_cs, 0);
      check({tag, "_ram_we"}, ram_we, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
      check({tag, "_if_data"}, if_data, 0);
      check({tag, "_d_rdata"}, d_rdata, 0);
      check({tag, "_if_ready"}, if_ready, 0);
      check({tag, "_d_ready"}, d_ready, 0);
   endtask

   // Memory: acks after a configurable wait and checks the strobe stays stable.
   initial begin
      ram_ack   = 1'b0;
      ram_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !mem_auto) begin
            ram_ack   = manual_ack;
            wait_left = -1;
         end else if (ram_ack) begin
            ram_ack = 1'b0;
         end else if (ram_cs) begin
            if (wait_left < 0) begin
               wait_left = (mem_wait_cfg < 0) ? int'($urandom_range(0, 3)) : mem_wait_cfg;
               cs_addr   = ram_addr;
               cs_we     = ram_we;
               cs_wdata  = ram_wdata;
            end else begin
               check("ram_addr_stable", ram_addr, cs_addr);
               check("ram_we_stable", ram_we, cs_we);
               if (cs_we) check("ram_wdata_stable", ram_wdata, cs_wdata);
            end
            if (wait_left == 0) begin
               ram_ack   = 1'b1;
               wait_left = -1;
               if (cs_we) begin
                  tb_mem[cs_addr] = cs_wdata;
                  ram_rdata       = $urandom;
               end else begin
                  ram_rdata = mem_read(cs_addr);
               end
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every ready pulse and checks the stall outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (if_ready) begin
               if (if_q.size() == 0) fail("if_ready_unexpected");
               else check("if_data", if_data, if_q.pop_front());
            end
            if (d_ready) begin
               if (d_q.size() == 0) fail("d_ready_unexpected");
               else check("d_rdata", d_rdata, d_q.pop_front());
            end
            check("stall_if", stall_if, if_req & ~if_ready);
            check("stall_mem", stall_mem, (d_ren | d_wen) & ~d_ready);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int if_at, d1_at, d2_at, d_cnt, rdy_cnt, cs_rise;
      logic ir, dr, prev_cs;

      rst = 1'b1;
      if_req = 0; if_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      step();
      rst = 1'b0;
      step();

      // Single IF read, zero wait.
      mem_wait_cfg = 0;
      tb_mem[32'h10]  = 32'h2002_0005;
      ref_mem[32'h10] = 32'h2002_0005;
      if_req = 1; if_addr = 32'h10;
      if_q.push_back(ref_read(32'h10));
      @(negedge clk);
      check("if1_cs_n0", ram_cs, 0);
      check("if1_stall_n0", stall_if, 1);
      @(negedge clk);
      check("if1_cs_n1", ram_cs, 1);
      check("if1_addr_n1", ram_addr, 32'h10);
      check("if1_we_n1", ram_we, 0);
      check("if1_stall_n1", stall_if, 1);
      @(negedge clk);
      check("if1_ready_n2", if_ready, 1);
      check("if1_cs_n2", ram_cs, 0);
      step();
      if_req = 0;
      @(negedge clk);
      check("if1_ready_n3", if_ready, 0);
      check("if1_cs_n3", ram_cs, 0);
      step();

      // Data write with three wait cycles.
      mem_wait_cfg = 3;
      d_wen = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      d_q.push_back(last_d);
      @(negedge clk);
      check("wr_cs_n0", ram_cs, 0);
      check("wr_stall_n0", stall_mem, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("wr_cs", ram_cs, 1);
         check("wr_we", ram_we, 1);
         check("wr_addr", ram_addr, 32'h40);
         check("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
         check("wr_ready_low", d_ready, 0);
      end
      @(negedge clk);
      check("wr_ready_n5", d_ready, 1);
      step();
      d_wen = 0;
      @(negedge clk);
      check("wr_ready_n6", d_ready, 0);
      step();

      // Collision: IF and data together, data re-requests once after its first ready.
      rst = 1'b1;
      last_d = 32'h0;
      step();
      rst = 1'b0;
      step();
      mem_wait_cfg = 0;
      if_req = 1; if_addr = 32'h20;
      d_ren = 1; d_addr = 32'h40;
      if_q.push_back(ref_read(32'h20));
      last_d = ref_read(32'h40);
      d_q.push_back(last_d);
      if_at = -1; d1_at = -1; d2_at = -1; d_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         ir = if_ready;
         dr = d_ready;
         if (ir) if_at = c;
         if (dr) begin
            if (d_cnt == 0) d1_at = c;
            else d2_at = c;
            d_cnt++;
         end
         step();
         if (ir) if_req = 0;
         if (dr) begin
            if (d_cnt == 1) begin
               d_addr = 32'h44;
               last_d = ref_read(32'h44);
               d_q.push_back(last_d);
            end else begin
               d_ren = 0;
            end
         end
      end
      check("coll_d1_cycle", d1_at, 2);
`ifdef MEM_ARB_RR_EN
      check("coll_if_cycle", if_at, 5);
      check("coll_d2_cycle", d2_at, 8);
`else
      check("coll_d2_cycle", d2_at, 5);
      check("coll_if_cycle", if_at, 8);
`endif

      // Flush: IF request dropped one cycle after grant still completes once.
      mem_wait_cfg = 2;
      if_req = 1; if_addr = 32'h30;
      if_q.push_back(ref_read(32'h30));
      @(negedge clk);
      prev_cs = ram_cs;
      step();
      if_req = 0;
      rdy_cnt = 0; cs_rise = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (if_ready) rdy_cnt++;
         if (ram_cs && !prev_cs) cs_rise++;
         prev_cs = ram_cs;
      end
      check("flush_ready_count", rdy_cnt, 1);
      check("flush_cs_count", cs_rise, 1);
      check("flush_stall_if", stall_if, 0);
      step();

      // Async reset during a long data read; then a late/spurious ack.
      mem_auto = 1'b0;
      manual_ack = 1'b0;
      d_ren = 1; d_addr = 32'h40;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_cs_before", ram_cs, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      d_ren = 0;
      last_d = 32'h0;
      step();
      rst = 1'b0;
      manual_ack = 1'b1;
      step();
      manual_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("late_ack_cs", ram_cs, 0);
         check("late_ack_if_ready", if_ready, 0);
         check("late_ack_d_ready", d_ready, 0);
      end
      step();
      mem_auto = 1'b1;
      mem_wait_cfg = 0;
      step();

      // FSM must still be idle: a fresh IF read takes the minimum latency.
      if_req = 1; if_addr = 32'h10;
      if_q.push_back(ref_read(32'h10));
      @(negedge clk);
      @(negedge clk);
      check("post_ack_cs_n1", ram_cs, 1);
      @(negedge clk);
      check("post_ack_ready_n2", if_ready, 1);
      step();
      if_req = 0;
      step();

      // Randomized traffic on both ports concurrently.
      mem_wait_cfg = -1;
      fork
         begin : if_proc
            logic [31:0] a;
            bit got;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) step();
               a = 32'h0001_0000 | ($urandom_range(0, 16383) << 2);
               if_addr = a;
               if_req = 1;
               if_q.push_back(ref_read(a));
               got = 0;
               for (int c = 0; c < 60 && !got; c++) begin
                  @(negedge clk);
                  got = if_ready;
               end
               if (!got) fail("if_ready_timeout");
               step();
               if_req = 0;
            end
         end
         begin : d_proc
            logic [31:0] a;
            int op;
            bit got;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) step();
               a = 32'h8000_0000 | ($urandom_range(0, 7) << 2);
               op = int'($urandom_range(0, 3));
               d_addr = a;
               if (op >= 2) begin
                  d_wdata = $urandom;
                  d_wen = 1;
                  d_ren = (op == 3);
                  ref_mem[a] = d_wdata;
               end else begin
                  d_ren = 1;
                  last_d = ref_read(a);
               end
               d_q.push_back(last_d);
               got = 0;
               for (int c = 0; c < 60 && !got; c++) begin
                  @(negedge clk);
                  got = d_ready;
               end
               if (!got) fail("d_ready_timeout");
               step();
               d_ren = 0;
               d_wen = 0;
            end
         end
      join

      repeat (5) @(negedge clk);
      check("if_queue_drained", if_q.size(), 0);
      check("d_queue_drained", d_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
